uart_tx: RTL and testbench

//  Serial UART transmitter for the FIR datapath. Accepts one byte per txd_start/txd_busy handshake
//  and shifts it out as an 8-bit frame: start bit, data LSB first, optional parity bit, stop bit(s).

---
 rtl/uart_tx.sv | 176 +++++++++++++++++
 tb/tb_uart_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter, start bit + 8 data bits LSB first (+ even parity) + stop bit(s).
// Latency: registered outputs; the start bit goes out on the same edge that accepts txd_start.
// Backpressure: txd_busy stays high for the whole frame; txd_start seen while busy is dropped.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit between bit 7 and stop.

module uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txd_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       txd_busy
);

    // Cycles per bit; the integer division truncates, so the real baud rate is slightly high
    // when CLK_FREQ is not an exact multiple of BAUD. Must be >= 2.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // Stop-bit counter is a single bit: value of the last stop bit (0 for one, 1 for two).
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q,  baud_d;
    logic [2:0]       bit_q,   bit_d;
    logic             stop_q,  stop_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q,   txd_d;
    logic             busy_q,  busy_d;
    logic             bit_end;

    // Last cycle of the current bit-time.
    assign bit_end = (baud_q == BAUD_LAST);

    // Next-state and next-output logic; txd/txd_busy are computed here and registered below,
    // so the line only ever changes on a clock edge at a bit boundary.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                bit_d  = '0;
                stop_d = 1'b0;
                if (txd_start) begin
                    shift_d = tx_data;
                    state_d = S_START;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        // Shift register is never shifted, so its XOR is the even parity bit.
                        state_d = S_PARITY;
                        txd_d   = ^shift_q;
`else
                        state_d = S_STOP;
                        stop_d  = 1'b0;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shift_q[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                    txd_d   = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif

            S_STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    baud_d = '0;
                    if (stop_q == STOP_LAST) begin
                        // Frame done: line stays high, busy drops on this same edge.
                        stop_d  = 1'b0;
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        stop_d = ~stop_q;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                stop_d  = 1'b0;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset; a reset mid-frame
    // abandons the frame and returns the line to idle-high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign txd      = txd_q;
    assign txd_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a frame-level line model and per-cycle compare.
// Latency: model expects the start bit on the accepting edge and busy for the whole frame.
// Backpressure: stimulus mimics the wrapper, pulsing txd_start only when txd_busy is low.

module tb_uart_tx;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD      = 100_000;
    localparam int STOP_BITS = 1;
    localparam int CPB       = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (1 + 8 + P + STOP_BITS) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       txd_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       txd;
    logic       txd_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .txd_start(txd_start),
        .tx_data  (tx_data),
        .txd      (txd),
        .txd_busy (txd_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Line model: a frame is a list of bit values, each held CPB cycles after acceptance.
    function automatic logic [11:0] frame_bits(input logic [7:0] d);
        logic [11:0] r;
        r    = '1;
        r[0] = 1'b0;
        for (int i = 0; i < 8; i++) r[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        r[9] = ^d;
`endif
        return r;
    endfunction

    logic        m_busy = 1'b0;
    int          m_pos  = 0;
    logic [11:0] m_bits = '1;

    // Model advances on the same edges the DUT sees.
    always @(posedge clk) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_pos  <= 0;
        end else if (m_busy) begin
            if (m_pos == FRAME - 1) m_busy <= 1'b0;
            m_pos <= m_pos + 1;
        end else if (txd_start) begin
            m_bits <= frame_bits(tx_data);
            m_busy <= 1'b1;
            m_pos  <= 0;
        end
    end

    // Per-cycle compare of {txd_busy, txd} against the model, away from the active edge.
    always @(negedge clk) begin
        logic exp_txd;
        int   idx;
        if (cyc > 0) begin
            idx     = m_pos / CPB;
            exp_txd = m_busy ? m_bits[idx] : 1'b1;
            check("line", {30'd0, txd_busy, txd}, {30'd0, m_busy, exp_txd});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-cycle txd_start pulse; returns just after the accepting edge.
    task automatic send(input logic [7:0] d);
        @(posedge clk);
        #2;
        txd_start = 1'b1;
        tx_data   = d;
        @(posedge clk);
        #2;
        txd_start = 1'b0;
    endtask

    // Line decoder: finds the start bit and samples each bit at its middle.
    task automatic recv(output logic [7:0] d, output logic p, input string nm);
        int n;
        n = 0;
        d = 8'h00;
        p = 1'b0;
        @(negedge clk);
        while (txd !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            check({nm, "_start_timeout"}, 32'd1, 32'd0);
        end else begin
            repeat (CPB / 2) @(negedge clk);
            check({nm, "_startbit"}, {31'd0, txd}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                d[i] = txd;
            end
            if (P == 1) begin
                repeat (CPB) @(negedge clk);
                p = txd;
            end
            repeat (CPB) @(negedge clk);
            check({nm, "_stopbit"}, {31'd0, txd}, 32'd1);
        end
    endtask

    // Counts edges from now until txd_busy is seen low.
    task automatic wait_busy_low(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (txd_busy && cnt < 1000);
        if (cnt >= 1000) check("busy_fall_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rp;
        int         n;
        int         t0;
        logic       seen;

        // 1. Reset held with txd_start asserted: line idle, no frame.
        rst       = 1'b0;
        txd_start = 1'b1;
        tx_data   = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_txd", {31'd0, txd}, 32'd1);
            check("rst_busy", {31'd0, txd_busy}, 32'd0);
        end
        #1;
        txd_start = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);

        // 2. Single byte 0xA5.
        fork
            begin
                recv(rb, rp, "a5");
                check("a5_byte", {24'd0, rb}, 32'hA5);
                if (P == 1) check("a5_parity", {31'd0, rp}, 32'd0);
            end
            begin
                send(8'hA5);
                #1;
                check("a5_busy_next", {31'd0, txd_busy}, 32'd1);
                check("a5_first_bit", {31'd0, txd}, 32'd0);
                wait_busy_low(n);
                check("a5_busy_len", n, FRAME);
            end
        join
        repeat (5) @(posedge clk);

`ifdef UART_TX_PARITY_EN
        // 3. Parity values.
        fork
            begin
                recv(rb, rp, "p07");
                check("p07_byte", {24'd0, rb}, 32'h07);
                check("p07_parity", {31'd0, rp}, 32'd1);
            end
            send(8'h07);
        join
        repeat (20) @(posedge clk);
        fork
            begin
                recv(rb, rp, "p00");
                check("p00_byte", {24'd0, rb}, 32'h00);
                check("p00_parity", {31'd0, rp}, 32'd0);
            end
            send(8'h00);
        join
        repeat (20) @(posedge clk);
`endif

        // 4. txd_start during a frame is ignored.
        fork
            begin
                recv(rb, rp, "ff");
                check("ff_byte", {24'd0, rb}, 32'hFF);
            end
            begin
                send(8'hFF);
                repeat (39) @(posedge clk);
                #2;
                txd_start = 1'b1;
                tx_data   = 8'h3C;
                @(posedge clk);
                #2;
                txd_start = 1'b0;
            end
        join
        wait_busy_low(n);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd_busy || !txd) seen = 1'b1;
        end
        check("ff_no_second_frame", {31'd0, seen}, 32'd0);

        // 5. Back-to-back frames driven on each busy fall.
        fork
            begin
                for (int k = 1; k <= 5; k++) begin
                    recv(rb, rp, "b2b");
                    check($sformatf("b2b_byte%0d", k), {24'd0, rb}, k);
                end
            end
            begin
                send(8'h01);
                t0 = cyc;
                for (int k = 2; k <= 5; k++) begin
                    wait_busy_low(n);
                    #1;
                    txd_start = 1'b1;
                    tx_data   = 8'(k);
                    @(posedge clk);
                    #2;
                    txd_start = 1'b0;
                    #1;
                    check("b2b_busy_rise", {31'd0, txd_busy}, 32'd1);
                end
                wait_busy_low(n);
                check("b2b_total_len", cyc - t0, 5 * FRAME + 4);
            end
        join
        repeat (5) @(posedge clk);

        // 6. Reset during bit 3 of 0x00, then a fresh frame.
        send(8'h00);
        repeat (44) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_txd", {31'd0, txd}, 32'd1);
        check("midrst_busy", {31'd0, txd_busy}, 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        fork
            begin
                recv(rb, rp, "5a");
                check("5a_byte", {24'd0, rb}, 32'h5A);
                if (P == 1) check("5a_parity", {31'd0, rp}, 32'd0);
            end
            send(8'h5A);
        join
        wait_busy_low(n);
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
